// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer: FSM states,
// command codes, ALU control encodings and flag bit positions.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  localparam logic [3:0] ALU_SEQ_OP_AND   = 4'h0;
  localparam logic [3:0] ALU_SEQ_OP_OR    = 4'h1;
  localparam logic [3:0] ALU_SEQ_OP_ADD   = 4'h2;
  localparam logic [3:0] ALU_SEQ_OP_SUB   = 4'h3;
  localparam logic [3:0] ALU_SEQ_OP_SLT   = 4'h4;
  localparam logic [3:0] ALU_SEQ_OP_SHIFT = 4'h5;
  localparam logic [3:0] ALU_SEQ_OP_CMP   = 4'h6;
  localparam logic [3:0] ALU_SEQ_OP_MOV   = 4'h7;

  localparam logic [3:0] ALU_CONT_AND   = 4'b0000;
  localparam logic [3:0] ALU_CONT_OR    = 4'b0001;
  localparam logic [3:0] ALU_CONT_ADD   = 4'b0010;
  localparam logic [3:0] ALU_CONT_SUB   = 4'b1110;
  localparam logic [3:0] ALU_CONT_SLT   = 4'b1111;
  localparam logic [3:0] ALU_CONT_SHIFT = 4'b0100;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_F = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/alu_seq_decode.sv
// Command decoder: op code to ALU control and command attributes.
// CMP is only a legal command when ALU_SEQ_FLAGS_EN is defined.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  output logic [3:0] alu_cont,
  output logic       writes_back,
  output logic       sets_flags,
  output logic       is_mov,
  output logic       legal
);

  always_comb begin
    alu_cont    = ALU_CONT_AND;
    writes_back = 1'b0;
    sets_flags  = 1'b0;
    is_mov      = 1'b0;
    legal       = 1'b1;
    case (op)
      ALU_SEQ_OP_AND:   writes_back = 1'b1;
      ALU_SEQ_OP_OR: begin
        alu_cont    = ALU_CONT_OR;
        writes_back = 1'b1;
      end
      ALU_SEQ_OP_ADD: begin
        alu_cont    = ALU_CONT_ADD;
        writes_back = 1'b1;
        sets_flags  = 1'b1;
      end
      ALU_SEQ_OP_SUB: begin
        alu_cont    = ALU_CONT_SUB;
        writes_back = 1'b1;
        sets_flags  = 1'b1;
      end
      ALU_SEQ_OP_SLT: begin
        alu_cont    = ALU_CONT_SLT;
        writes_back = 1'b1;
      end
      ALU_SEQ_OP_SHIFT: begin
        alu_cont    = ALU_CONT_SHIFT;
        writes_back = 1'b1;
      end
      ALU_SEQ_OP_CMP: begin
`ifdef ALU_SEQ_FLAGS_EN
        alu_cont   = ALU_CONT_SUB;
        sets_flags = 1'b1;
`else
        legal      = 1'b0;
`endif
      end
      ALU_SEQ_OP_MOV: begin
        writes_back = 1'b1;
        is_mov      = 1'b1;
      end
      default:          legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Four-cycle ALU command sequencer: register read, execute, writeback.
// Status flags and the CMP command exist only with ALU_SEQ_FLAGS_EN defined.
//   state | meaning
//   IDLE  | ready for a command
//   READ  | register-file addresses driven
//   EXEC  | ALU operands driven, result and flags captured
//   WB    | result written back, done pulsed
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int REGS_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_op,
  input  logic [REGS_LOG2-1:0] cmd_rdest,
  input  logic [REGS_LOG2-1:0] cmd_rsrc,
  input  logic [7:0]           cmd_imm,
  input  logic                 cmd_use_imm,
  output logic [REGS_LOG2-1:0] rf_raddr_a,
  output logic [REGS_LOG2-1:0] rf_raddr_b,
  input  logic [WIDTH-1:0]     rf_rdata_a,
  input  logic [WIDTH-1:0]     rf_rdata_b,
  output logic                 rf_we,
  output logic [REGS_LOG2-1:0] rf_waddr,
  output logic [WIDTH-1:0]     rf_wdata,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [3:0]           alu_cont,
  output logic                 alu_cin,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_cout,
  output logic [3:0]           flags,
  output logic                 done,
  output logic                 busy
);

  state_e               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [REGS_LOG2-1:0] rdest_q, rdest_d;
  logic [REGS_LOG2-1:0] rsrc_q, rsrc_d;
  logic [7:0]           imm_q, imm_d;
  logic                 use_imm_q, use_imm_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic [3:0]           dec_alu_cont;
  logic                 dec_writes_back;
  logic                 dec_sets_flags;
  logic                 dec_is_mov;
  logic                 dec_legal;
  logic [WIDTH-1:0]     opnd_b;

  alu_seq_decode u_decode (
    .op          (op_q),
    .alu_cont    (dec_alu_cont),
    .writes_back (dec_writes_back),
    .sets_flags  (dec_sets_flags),
    .is_mov      (dec_is_mov),
    .legal       (dec_legal)
  );

  assign opnd_b = use_imm_q ? {{(WIDTH-8){imm_q[7]}}, imm_q} : rf_rdata_b;
  assign busy   = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rdest_d    = rdest_q;
    rsrc_d     = rsrc_q;
    imm_d      = imm_q;
    use_imm_d  = use_imm_q;
    result_d   = result_q;
    cmd_ready  = 1'b0;
    rf_raddr_a = '0;
    rf_raddr_b = '0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_cont   = '0;
    alu_cin    = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d      = cmd_op;
          rdest_d   = cmd_rdest;
          rsrc_d    = cmd_rsrc;
          imm_d     = cmd_imm;
          use_imm_d = cmd_use_imm;
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        rf_raddr_a = rdest_q;
        rf_raddr_b = rsrc_q;
        state_d    = ST_EXEC;
      end
      ST_EXEC: begin
        alu_a    = rf_rdata_a;
        alu_b    = opnd_b;
        alu_cont = dec_alu_cont;
        // MOV bypasses the ALU; illegal ops leave the result register alone
        if (dec_legal) result_d = dec_is_mov ? opnd_b : alu_result;
        state_d  = ST_WB;
      end
      ST_WB: begin
        rf_we    = dec_writes_back;
        rf_waddr = rdest_q;
        rf_wdata = result_q;
        done     = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      rdest_q   <= '0;
      rsrc_q    <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rdest_q   <= rdest_d;
      rsrc_q    <= rsrc_d;
      imm_q     <= imm_d;
      use_imm_q <= use_imm_d;
      result_q  <= result_d;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [3:0] flags_q, flags_d;
  logic       sign_a, sign_b, sign_r, ovf_cand;

  assign sign_a = rf_rdata_a[WIDTH-1];
  assign sign_b = opnd_b[WIDTH-1];
  assign sign_r = alu_result[WIDTH-1];
  // ADD overflows from like-signed operands, SUB/CMP from unlike-signed ones
  assign ovf_cand = (op_q == ALU_SEQ_OP_ADD) ? (sign_a == sign_b) : (sign_a != sign_b);

  always_comb begin
    flags_d = flags_q;
    if (state_q == ST_EXEC && dec_sets_flags) begin
      flags_d[FLAG_N] = sign_r;
      flags_d[FLAG_Z] = (alu_result == '0);
      flags_d[FLAG_F] = ovf_cand & (sign_r != sign_a);
      flags_d[FLAG_C] = alu_cout;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flags_q <= '0;
    else          flags_q <= flags_d;
  end

  assign flags = flags_q;
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{alu_cout, dec_sets_flags};
  assign flags = '0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU and register file;
// flag expectations follow whether ALU_SEQ_FLAGS_EN is defined.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int W  = 16;
  localparam int RL = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = '0;
  logic [RL-1:0] cmd_rdest = '0;
  logic [RL-1:0] cmd_rsrc = '0;
  logic [7:0]    cmd_imm = '0;
  logic          cmd_use_imm = 1'b0;
  logic [RL-1:0] rf_raddr_a, rf_raddr_b;
  logic [W-1:0]  rf_rdata_a, rf_rdata_b;
  logic          rf_we;
  logic [RL-1:0] rf_waddr;
  logic [W-1:0]  rf_wdata;
  logic [W-1:0]  alu_a, alu_b;
  logic [3:0]    alu_cont;
  logic          alu_cin;
  logic [W-1:0]  alu_result;
  logic          alu_cout;
  logic [3:0]    flags;
  logic          done;
  logic          busy;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(W), .REGS_LOG2(RL)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rdest(cmd_rdest), .cmd_rsrc(cmd_rsrc), .cmd_imm(cmd_imm),
    .cmd_use_imm(cmd_use_imm),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cont(alu_cont), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .flags(flags), .done(done), .busy(busy)
  );

  // behavioural ALU
  logic [W:0] sum17;
  always_comb begin
    sum17      = '0;
    alu_result = '0;
    alu_cout   = 1'b0;
    case (alu_cont)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: begin
        sum17 = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
        {alu_cout, alu_result} = sum17;
      end
      4'b1110: begin
        sum17 = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, 1'b1};
        {alu_cout, alu_result} = sum17;
      end
      4'b1111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 16'd1 : 16'd0;
      4'b0100: alu_result = alu_a << alu_b[3:0];
      default: alu_result = '0;
    endcase
  end

  // register file: read data one cycle after address, write at end of cycle
  logic [W-1:0] regs [16];
  always @(posedge clk) begin
    rf_rdata_a <= regs[rf_raddr_a];
    rf_rdata_b <= regs[rf_raddr_b];
    if (rf_we) regs[rf_waddr] <= rf_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] fl(input logic [3:0] f);
`ifdef ALU_SEQ_FLAGS_EN
    return f;
`else
    return 4'b0000;
`endif
  endfunction

  typedef struct {
    logic         wb;
    logic [3:0]   waddr;
    logic [W-1:0] wdata;
    logic [3:0]   flags;
    int           cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // monitor: every done pulse is matched against the oldest issued command
  always @(negedge clk) begin
    if (reset_n) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_empty: got done=1 expected no retirement");
        end else begin
          mon_e = sb_q.pop_front();
          chk("done_latency", cyc, mon_e.cyc + 3);
          chk("rf_we", {31'd0, rf_we}, {31'd0, mon_e.wb});
          if (mon_e.wb) begin
            chk("rf_waddr", {28'd0, rf_waddr}, {28'd0, mon_e.waddr});
            chk("rf_wdata", {16'd0, rf_wdata}, {16'd0, mon_e.wdata});
          end
          chk("flags", {28'd0, flags}, {28'd0, mon_e.flags});
        end
      end else if (rf_we) begin
        n_total++;
        $display("FAIL stray_we: got rf_we=1 expected 0 outside done");
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [7:0] imm, input logic ui, input logic wb,
                       input logic [W-1:0] wdata, input logic [3:0] fexp, output int acc);
    exp_t e;
    int n;
    @(negedge clk);
    cmd_op = op; cmd_rdest = rd; cmd_rsrc = rs; cmd_imm = imm; cmd_use_imm = ui;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_total++;
      $display("FAIL accept_timeout: got cmd_ready=0 expected 1");
      acc = -1;
    end else begin
      acc = cyc;
      e.wb = wb; e.waddr = rd; e.wdata = wdata; e.flags = fexp; e.cyc = cyc;
      sb_q.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2;
    for (int i = 0; i < 16; i++) regs[i] <= '0;
    regs[1]  <= 16'h7FFF; regs[2]  <= 16'h0001;
    regs[3]  <= 16'h0005;
    regs[4]  <= 16'h1234; regs[5]  <= 16'h1234;
    regs[6]  <= 16'h0F0F; regs[7]  <= 16'h00FF;
    regs[10] <= 16'h0003;
    regs[11] <= 16'hFFFE; regs[12] <= 16'h0001;
    regs[13] <= 16'h0001; regs[14] <= 16'h0001;

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_rf_we", {31'd0, rf_we}, 0);
    chk("rst_flags", {28'd0, flags}, 0);
    chk("rst_alu_a", {16'd0, alu_a}, 0);
    reset_n = 1'b1;

    // ADD with signed overflow
    issue(ALU_SEQ_OP_ADD, 4'd1, 4'd2, 8'h00, 1'b0, 1'b1, 16'h8000, fl(4'b1010), a0);
    @(negedge clk); cmd_valid = 1'b0;
    drain();
    @(negedge clk);
    chk("r1_after_add", {16'd0, regs[1]}, 32'h8000);

    // SUB with sign-extended immediate -1
    issue(ALU_SEQ_OP_SUB, 4'd3, 4'd0, 8'hFF, 1'b1, 1'b1, 16'h0006, fl(4'b0000), a0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("read_ready", {31'd0, cmd_ready}, 0);
    chk("read_raddr_a", {28'd0, rf_raddr_a}, 3);
    @(negedge clk);
    chk("exec_ready", {31'd0, cmd_ready}, 0);
    chk("exec_alu_a", {16'd0, alu_a}, 32'h0005);
    chk("exec_alu_b", {16'd0, alu_b}, 32'hFFFF);
    chk("exec_alu_cont", {28'd0, alu_cont}, 32'hE);
    chk("exec_alu_cin", {31'd0, alu_cin}, 0);
    @(negedge clk);
    chk("wb_ready", {31'd0, cmd_ready}, 0);
    drain();

    // CMP: flags only, never a writeback
    issue(ALU_SEQ_OP_CMP, 4'd4, 4'd5, 8'h00, 1'b0, 1'b0, 16'h0000, fl(4'b0101), a0);
    @(negedge clk); cmd_valid = 1'b0;
    drain();

    // three back-to-back commands with cmd_valid held high
    issue(ALU_SEQ_OP_OR,  4'd6, 4'd7, 8'h00, 1'b0, 1'b1, 16'h0FFF, fl(4'b0101), a0);
    issue(ALU_SEQ_OP_AND, 4'd6, 4'd7, 8'h00, 1'b0, 1'b1, 16'h00FF, fl(4'b0101), a1);
    issue(ALU_SEQ_OP_MOV, 4'd8, 4'd0, 8'h80, 1'b1, 1'b1, 16'hFF80, fl(4'b0101), a2);
    @(negedge clk); cmd_valid = 1'b0;
    chk("b2b_gap1", a1 - a0, 4);
    chk("b2b_gap2", a2 - a1, 4);
    drain();

    // illegal op retires without writeback
    issue(4'hA, 4'd9, 4'd0, 8'h00, 1'b0, 1'b0, 16'h0000, fl(4'b0101), a0);
    @(negedge clk); cmd_valid = 1'b0;
    drain();

    issue(ALU_SEQ_OP_SHIFT, 4'd10, 4'd0, 8'h04, 1'b1, 1'b1, 16'h0030, fl(4'b0101), a0);
    @(negedge clk); cmd_valid = 1'b0;
    drain();

    issue(ALU_SEQ_OP_SLT, 4'd11, 4'd12, 8'h00, 1'b0, 1'b1, 16'h0001, fl(4'b0101), a0);
    @(negedge clk); cmd_valid = 1'b0;
    drain();

    // reset during EXEC aborts the command
    issue(ALU_SEQ_OP_ADD, 4'd13, 4'd14, 8'h00, 1'b0, 1'b1, 16'h0002, fl(4'b0000), a0);
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    chk("exec_busy", {31'd0, busy}, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_rf_we", {31'd0, rf_we}, 0);
    chk("abort_flags", {28'd0, flags}, 0);
    chk("abort_ready", {31'd0, cmd_ready}, 1);
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("r13_no_wb", {16'd0, regs[13]}, 32'h0001);
    chk("idle_after_abort", {31'd0, busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller sitting between the instruction decoder and the 16-bit `alu` datapath. It accepts one register-register or register-immediate ALU command per handshake and reads both operands from the register file. It drives the ALU control and operand inputs, latches the result and the processor status flags, and writes the result back to the register file. One command is in flight at a time, with a fixed 4-cycle command-to-writeback latency.

## Interface
Parameters:
- `WIDTH`, default 16: datapath width; must be ≥ 9.
- `REGS_LOG2`, default 4: register-file address width.

Ports:
- `clk` in, 1: single clock; all state changes on the rising edge.
- `reset_n` in, 1: asynchronous, active-low reset.
- `cmd_valid` in, 1: command present.
- `cmd_ready` out, 1: sequencer can accept a command.
- `cmd_op` in, 4: command code (`ALU_SEQ_OP_*`).
- `cmd_rdest` in, REGS_LOG2: destination register; also operand A.
- `cmd_rsrc` in, REGS_LOG2: operand B register.
- `cmd_imm` in, 8: immediate value.
- `cmd_use_imm` in, 1: take operand B from the sign-extended `cmd_imm` instead of `cmd_rsrc`.
- `rf_raddr_a`, `rf_raddr_b` out, REGS_LOG2: register-file read addresses.
- `rf_rdata_a`, `rf_rdata_b` in, WIDTH: register-file read data, valid one cycle after the address.
- `rf_we` out, 1: writeback strobe.
- `rf_waddr` out, REGS_LOG2: writeback address.
- `rf_wdata` out, WIDTH: writeback data.
- `alu_a`, `alu_b` out, WIDTH: ALU operands.
- `alu_cont` out, 4: ALU control.
- `alu_cin` out, 1: ALU carry-in.
- `alu_result` in, WIDTH: ALU result.
- `alu_cout` in, 1: ALU carry-out.
- `flags` out, 4: status flags {N, Z, F, C}.
- `done` out, 1: one-cycle pulse when a command retires.
- `busy` out, 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE → READ → EXEC → WB → IDLE; encoding is defined in the package.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, register the command fields and go to READ.
- **READ:**
  - Drive `rf_raddr_a`=rdest and `rf_raddr_b`=rsrc.
  - Go to EXEC.
- **EXEC:**
  - `alu_a` = `rf_rdata_a`.
  - `alu_b` = use_imm ? sign-extended imm (bit 7 replicated to WIDTH) : `rf_rdata_b`.
  - `alu_cont` comes from the decode of the registered op; `alu_cin`=0.
  - At the edge, capture `alu_result` into the result register and update the flags when the op sets flags.
  - Go to WB.
- **WB:**
  - `rf_we` = writes_back(op); `rf_waddr`=rdest; `rf_wdata`=result register.
  - `done`=1. Go to IDLE.
- **Command codes → `alu_cont`:**

  | Code | Mnemonic | `alu_cont` | Writes back |
  |---|---|---|---|
  | 0x0 | AND | 0000 | yes |
  | 0x1 | OR | 0001 | yes |
  | 0x2 | ADD | 0010 | yes |
  | 0x3 | SUB | 1110 | yes |
  | 0x4 | SLT | 1111 | yes |
  | 0x5 | SHIFT | 0100 | yes |
  | 0x6 | CMP | 1110 | no |
  | 0x7 | MOV | operand B passed as result; ALU not used | yes |
  | 0x8–0xF | illegal | — | no; retires with `done`, flags unchanged |

- **Flags:** updated only by ADD, SUB and CMP.
  - Z = (result==0).
  - N = result[WIDTH-1].
  - C = `alu_cout`.
  - F = signed overflow: operand sign bits agree (ADD) or differ (SUB/CMP) and the result sign differs from `alu_a`.
- **Output values outside the driving state:** `alu_a`, `alu_b` and `alu_cont` are 0 outside EXEC. `rf_*` outputs are 0 outside their state.
- **Reset values:**
  - State = IDLE.
  - `flags`=0, result register=0.
  - `rf_we`=0, `done`=0, `busy`=0, `cmd_ready`=1.
- **Reset mid-operation:** abort immediately and asynchronously. No writeback occurs and the in-flight command is lost.

## Timing
- **Latency:** command accepted at edge N → READ in cycle N+1 → EXEC in N+2 → `rf_we`/`done` high in cycle N+3. Throughput is one command per 4 cycles.
- **Handshake:**
  - `cmd_ready` depends only on state; it has no combinational path from `cmd_valid`.
  - Command fields are sampled only at the handshake edge.
  - Changes to the command inputs while busy have no effect.
- **Back-to-back commands:** `cmd_ready` returns to 1 in the cycle after WB. A command reading the register written in WB sees the new value, because the register file writes at the end of WB.
- `flags` changes at the end of EXEC, one cycle before `done`.

## Configuration
- **`ALU_SEQ_FLAGS_EN` defined:** flag register, F/C/N/Z logic and the CMP command are present as described above.
- **Not defined:**
  - `flags` is tied to 0 and no flag register is instantiated.
  - CMP behaves as an illegal op: retires with `done`, no writeback.
  - All other behaviour and timing are unchanged.

## Structure
- **Package `alu_seq_pkg`:**
  - State enum.
  - `ALU_SEQ_OP_*` command codes.
  - `ALU_CONT_*` control constants (AND, OR, ADD, SUB, SLT, SHIFT).
  - Flag bit indices (N=3, Z=2, F=1, C=0).
- **Sub-module `alu_seq_decode`:** combinational, op → {`alu_cont`, writes_back, sets_flags, is_mov, legal}. It is instantiated once in the sequencer.

## Test plan
- **ADD:** R1=0x7FFF, R2=0x0001, ADD rdest=1 rsrc=2 → `rf_we` at accept+3 writing 0x8000 to R1; flags N=1 Z=0 F=1 C=0.
- **Immediate sign extension:** SUB with imm 0xFF (−1), R3=0x0005 → `alu_b`=0xFFFF in EXEC; R3 ← 0x0006.
- **CMP:** R4=R5=0x1234, CMP → `rf_we` never asserted; Z=1 N=0; `done` one pulse.
- **Handshake:** `cmd_valid` held high for 3 commands → exactly 3 `done` pulses, 4 cycles apart; `cmd_ready`=0 in READ/EXEC/WB.
- **Reset mid-operation:** assert `reset_n`=0 during EXEC → `rf_we`, `done` and `busy` go to 0 immediately; `flags`=0; no writeback after release.
- **Illegal op and macro off:** op 0xA → `done` at accept+3 with no `rf_we`. With `ALU_SEQ_FLAGS_EN` undefined, ADD leaves `flags`=0.
